// File: rtl/pir_pkg.sv
// pir_pkg -- shared types and constants for the PIR scan scheduler.
//   pir_state_t           : scheduler FSM state encoding
//   SENSOR_ID_1..3        : event id values reported on evt_id
//   DEFAULT_SAMPLE_DIV    : default cycles between sensor samples
//   DEFAULT_THRESH        : default motion threshold on the 7-bit averages
//   DEFAULT_HOLDOFF       : default per-sensor suppression length
//   SAMPLES_PER_ROUND     : 4 samples for each of the 3 sensors
package pir_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      EVAL   = 2'd2,
      REPORT = 2'd3
   } pir_state_t;

   localparam logic [1:0] SENSOR_ID_1 = 2'd1;
   localparam logic [1:0] SENSOR_ID_2 = 2'd2;
   localparam logic [1:0] SENSOR_ID_3 = 2'd3;

   localparam int DEFAULT_SAMPLE_DIV = 2;
   localparam int DEFAULT_THRESH     = 50;
   localparam int DEFAULT_HOLDOFF    = 100;

   localparam int SAMPLES_PER_ROUND  = 12;

endpackage

// File: rtl/pir_rr_pick.sv
// pir_rr_pick -- combinational round-robin picker over three pending sensors.
//   pend    in  3 : pending flags, bit i = sensor i+1
//   last_id in  2 : id of the last accepted event (0 or 3 both mean "start at 1")
//   id      out 2 : first pending sensor after last_id, 0 when none
//   found   out 1 : a pending sensor was found
module pir_rr_pick
   import pir_pkg::*;
(
   input  logic [2:0] pend,
   input  logic [1:0] last_id,
   output logic [1:0] id,
   output logic       found
);

   logic [1:0] order [3];

   // Search order begins with the sensor right after the last accepted one.
   always_comb begin
      case (last_id)
         SENSOR_ID_1: order = '{SENSOR_ID_2, SENSOR_ID_3, SENSOR_ID_1};
         SENSOR_ID_2: order = '{SENSOR_ID_3, SENSOR_ID_1, SENSOR_ID_2};
         default:     order = '{SENSOR_ID_1, SENSOR_ID_2, SENSOR_ID_3};
      endcase
   end

   // Walk from lowest priority to highest so the earliest hit in order wins.
   always_comb begin
      id    = 2'd0;
      found = 1'b0;
      for (int k = 2; k >= 0; k--) begin
         if (pend[order[k] - 2'd1]) begin
            id    = order[k];
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pir_scan_sched.sv
// pir_scan_sched -- samples three PIR sensors round-robin, averages four
// samples per sensor, and offers over-threshold sensors as valid/ready events.
//   clk, rst_n             : clock, synchronous active-low reset
//   turn                   : 1 runs scanning, 0 parks the block in IDLE
//   pir_sensor_1..3  in  7 : raw sensor levels
//   evt_valid/evt_ready    : event handshake
//   evt_id           out 2 : sensor number of the offered event (1..3)
//   evt_value        out 7 : average of the offered sensor
//   avg_1..3         out 7 : last computed averages
//   round_done       out 1 : one-cycle pulse in EVAL
//   busy             out 1 : high outside IDLE
// Optional feature: define PIR_HOLDOFF_EN to add per-sensor holdoff counters
// that suppress a sensor for HOLDOFF cycles after its event is accepted.
module pir_scan_sched
   import pir_pkg::*;
#(
   parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
   parameter int THRESH     = DEFAULT_THRESH,
   parameter int HOLDOFF    = DEFAULT_HOLDOFF
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       turn,
   input  logic [6:0] pir_sensor_1,
   input  logic [6:0] pir_sensor_2,
   input  logic [6:0] pir_sensor_3,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [1:0] evt_id,
   output logic [6:0] evt_value,
   output logic [6:0] avg_1,
   output logic [6:0] avg_2,
   output logic [6:0] avg_3,
   output logic       round_done,
   output logic       busy
);

   if (SAMPLE_DIV < 1 || SAMPLE_DIV > 15) begin : g_bad_div
      $error("pir_scan_sched: SAMPLE_DIV out of range 1..15");
   end
   if (HOLDOFF < 1 || HOLDOFF > 127) begin : g_bad_holdoff
      $error("pir_scan_sched: HOLDOFF out of range 1..127");
   end

   pir_state_t state, state_next;
   logic [3:0] div;
   logic [1:0] sel;
   logic [3:0] cnt;
   logic [8:0] acc [3];
   logic [6:0] avg [3];
   logic [6:0] avg_new [3];
   logic [2:0] pend, pend_eval, pend_after, pick_mask, suppress;
   logic [1:0] last_id, pick_id;
   logic       pick_found, div_tc, last_sample, transfer;
   logic [6:0] sample;

   pir_rr_pick u_pick (
      .pend    (pend),
      .last_id (last_id),
      .id      (pick_id),
      .found   (pick_found)
   );

   // Sample strobe, the sensor currently selected, and end-of-round detect.
   always_comb begin
      div_tc      = (div == 4'(SAMPLE_DIV - 1));
      last_sample = div_tc && (cnt == 4'(SAMPLES_PER_ROUND - 1));
      case (sel)
         2'd0:    sample = pir_sensor_1;
         2'd1:    sample = pir_sensor_2;
         default: sample = pir_sensor_3;
      endcase
   end

   // Averages and threshold test used when EVAL commits a round.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         avg_new[i]   = acc[i][8:2];
         pend_eval[i] = (int'(avg_new[i]) >= THRESH) && !suppress[i];
      end
   end

   // A transfer retires the picked sensor; a parked block never transfers.
   always_comb begin
      case (pick_id)
         SENSOR_ID_1: pick_mask = 3'b001;
         SENSOR_ID_2: pick_mask = 3'b010;
         SENSOR_ID_3: pick_mask = 3'b100;
         default:     pick_mask = 3'b000;
      endcase
      transfer   = (state == REPORT) && evt_ready && pick_found && turn;
      pend_after = pend & ~pick_mask;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and handshake outputs; turn=0 overrides every state.
   always_comb begin
      state_next = state;
      evt_valid  = (state == REPORT);
      round_done = (state == EVAL);
      busy       = (state != IDLE);
      evt_id     = 2'd0;
      evt_value  = 7'd0;
      if (state == REPORT) begin
         evt_id = pick_id;
         case (pick_id)
            SENSOR_ID_1: evt_value = avg[0];
            SENSOR_ID_2: evt_value = avg[1];
            SENSOR_ID_3: evt_value = avg[2];
            default:     evt_value = 7'd0;
         endcase
      end
      if (!turn) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = SAMPLE;
            SAMPLE:  if (last_sample) state_next = EVAL;
            EVAL:    state_next = (pend_eval != 3'b000) ? REPORT : SAMPLE;
            REPORT:  if (transfer && pend_after == 3'b000) state_next = SAMPLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Sampling datapath, round commit and pending-event bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div     <= '0;
         sel     <= '0;
         cnt     <= '0;
         pend    <= '0;
         last_id <= '0;
         for (int i = 0; i < 3; i++) begin
            acc[i] <= '0;
            avg[i] <= '0;
         end
      end else if (!turn || state == IDLE) begin
         div  <= '0;
         sel  <= '0;
         cnt  <= '0;
         pend <= '0;
         for (int i = 0; i < 3; i++) acc[i] <= '0;
      end else begin
         case (state)
            SAMPLE: begin
               if (div_tc) begin
                  div <= '0;
                  sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                  cnt <= last_sample ? 4'd0 : cnt + 4'd1;
                  for (int i = 0; i < 3; i++) begin
                     if (sel == 2'(i)) acc[i] <= acc[i] + {2'b00, sample};
                  end
               end else begin
                  div <= div + 4'd1;
               end
            end
            EVAL: begin
               pend <= pend_eval;
               for (int i = 0; i < 3; i++) begin
                  avg[i] <= avg_new[i];
                  acc[i] <= '0;
               end
            end
            REPORT: begin
               if (transfer) begin
                  pend    <= pend_after;
                  last_id <= pick_id;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PIR_HOLDOFF_EN
   logic [6:0] hold_cnt [3];

   // Holdoff counters: reload on the sensor's accepted event, count down while scanning.
   always_ff @(posedge clk) begin
      if (!rst_n || state == IDLE) begin
         for (int i = 0; i < 3; i++) hold_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (transfer && pick_mask[i])
               hold_cnt[i] <= 7'(HOLDOFF);
            else if (hold_cnt[i] != 7'd0 && turn)
               hold_cnt[i] <= hold_cnt[i] - 7'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) suppress[i] = (hold_cnt[i] != 7'd0);
   end
`else
   assign suppress = 3'b000;
`endif

   assign avg_1 = avg[0];
   assign avg_2 = avg[1];
   assign avg_3 = avg[2];

endmodule

// File: tb/tb_pir_scan_sched.sv
// tb_pir_scan_sched -- randomized bench for pir_scan_sched with a
// round-level reference model (sample timing, averages, round-robin order,
// optional holdoff by acceptance time).
module tb_pir_scan_sched;

   localparam int SD = 2;
   localparam int TH = 50;
   localparam int HO = 100;
`ifdef PIR_HOLDOFF_EN
   localparam bit HO_EN = 1'b1;
`else
   localparam bit HO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, turn, evt_ready;
   logic [6:0] pir_sensor_1, pir_sensor_2, pir_sensor_3;
   logic       evt_valid, round_done, busy;
   logic [1:0] evt_id;
   logic [6:0] evt_value, avg_1, avg_2, avg_3;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int exp_avg [3];
   int last_acc = 0;
   int acc_time [3];

   pir_scan_sched #(.SAMPLE_DIV(SD), .THRESH(TH), .HOLDOFF(HO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .turn         (turn),
      .pir_sensor_1 (pir_sensor_1),
      .pir_sensor_2 (pir_sensor_2),
      .pir_sensor_3 (pir_sensor_3),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_id       (evt_id),
      .evt_value    (evt_value),
      .avg_1        (avg_1),
      .avg_2        (avg_2),
      .avg_3        (avg_3),
      .round_done   (round_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Drive one cycle's inputs, let the edge take them, then settle.
   task automatic applyStimulus(input bit t, input bit r, input int s1, input int s2, input int s3);
      turn         = t;
      evt_ready    = r;
      pir_sensor_1 = 7'(s1);
      pir_sensor_2 = 7'(s2);
      pir_sensor_3 = 7'(s3);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic int rnd();
      return int'($urandom_range(0, 127));
   endfunction

   function automatic int getAvg(input int i);
      case (i)
         0:       return int'(avg_1);
         1:       return int'(avg_2);
         default: return int'(avg_3);
      endcase
   endfunction

   function automatic int rrPick(input int p [3], input int last);
      for (int k = 1; k <= 3; k++) begin
         int cand;
         cand = ((last + k - 1) % 3) + 1;
         if (p[cand-1] != 0) return cand;
      end
      return 0;
   endfunction

   function automatic void clearHoldoff();
      for (int i = 0; i < 3; i++) acc_time[i] = -100000;
   endfunction

   // One full round starting at the first SAMPLE cycle.
   // smode 0: random sensors each cycle, 1: fixed f1..f3.
   // rmode 0: random ready, 1: always ready, 2: ready low for first 5 offers.
   task automatic runRound(input int smode, input int f1, input int f2, input int f3,
                           input int rmode, input bit drop_turn);
      int sums [3];
      int v [3];
      int p [3];
      int npend, rep, id, eval_cyc, k;
      bit rdy;
      sums = '{0, 0, 0};
      checkOutput("sample_busy", int'(busy), 1);
      checkOutput("sample_valid", int'(evt_valid), 0);
      for (int c = 0; c < 12 * SD; c++) begin
         v[0] = smode ? f1 : rnd();
         v[1] = smode ? f2 : rnd();
         v[2] = smode ? f3 : rnd();
         if (c % SD == SD - 1) begin
            k = (c / SD) % 3;
            sums[k] += v[k];
         end
         checkOutput("round_done_early", int'(round_done), 0);
         applyStimulus(1'b1, 1'($urandom), v[0], v[1], v[2]);
      end
      checkOutput("round_done", int'(round_done), 1);
      checkOutput("eval_valid", int'(evt_valid), 0);
      eval_cyc = cyc;
      npend = 0;
      for (int i = 0; i < 3; i++) begin
         exp_avg[i] = sums[i] / 4;
         p[i] = (exp_avg[i] >= TH && !(HO_EN && (eval_cyc - acc_time[i] <= HO))) ? 1 : 0;
         npend += p[i];
      end
      applyStimulus(1'b1, 1'($urandom), rnd(), rnd(), rnd());
      for (int i = 0; i < 3; i++) checkOutput($sformatf("avg_%0d", i + 1), getAvg(i), exp_avg[i]);
      rep = 0;
      while (npend > 0) begin
         if (rep > 60) begin
            checkOutput("report_budget", rep, 0);
            break;
         end
         id = rrPick(p, last_acc);
         checkOutput("evt_valid", int'(evt_valid), 1);
         checkOutput("evt_id", int'(evt_id), id);
         checkOutput("evt_value", int'(evt_value), exp_avg[id-1]);
         if (drop_turn) begin
            applyStimulus(1'b0, 1'b0, rnd(), rnd(), rnd());
            checkOutput("drop_valid", int'(evt_valid), 0);
            checkOutput("drop_busy", int'(busy), 0);
            for (int j = 0; j < 3; j++) begin
               applyStimulus(1'b0, 1'($urandom), rnd(), rnd(), rnd());
               checkOutput("idle_avg", getAvg(j), exp_avg[j]);
               checkOutput("idle_busy", int'(busy), 0);
            end
            clearHoldoff();
            applyStimulus(1'b1, 1'b0, rnd(), rnd(), rnd());
            npend = 0;
            break;
         end
         rdy = (rmode == 1) ? 1'b1 : (rmode == 2) ? (rep >= 5) : 1'($urandom);
         applyStimulus(1'b1, rdy, rnd(), rnd(), rnd());
         if (rdy) begin
            p[id-1] = 0;
            last_acc = id;
            acc_time[id-1] = cyc - 1;
            npend--;
         end
         rep++;
      end
      checkOutput("post_valid", int'(evt_valid), 0);
      checkOutput("post_busy", int'(busy), 1);
   endtask

   initial begin
      rst_n = 1'b0;
      turn = 1'b0;
      evt_ready = 1'b0;
      pir_sensor_1 = '0;
      pir_sensor_2 = '0;
      pir_sensor_3 = '0;
      exp_avg = '{0, 0, 0};
      clearHoldoff();

      // Reset wins over turn and evt_ready.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 100, 100, 100);
      checkOutput("rst_valid", int'(evt_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_round_done", int'(round_done), 0);
      checkOutput("rst_id", int'(evt_id), 0);
      checkOutput("rst_value", int'(evt_value), 0);
      for (int i = 0; i < 3; i++) checkOutput("rst_avg", getAvg(i), 0);

      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 0, 0, 0);
      checkOutput("idle_parked", int'(busy), 0);
      applyStimulus(1'b1, 1'b0, 0, 0, 0);

      $display("[TB] single event, sensors 60/10/10");
      runRound(1, 60, 10, 10, 1, 1'b0);
      $display("[TB] threshold boundary, sensors 49/50/127");
      runRound(1, 49, 50, 127, 0, 1'b0);
      $display("[TB] back-pressure, sensors 80/80/80");
      runRound(1, 80, 80, 80, 2, 1'b0);
      $display("[TB] turn dropped during report");
      runRound(1, 80, 80, 80, 0, 1'b1);

      $display("[TB] reset mid-sample");
      for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b0, rnd(), rnd(), rnd());
      rst_n = 1'b0;
      applyStimulus(1'b1, 1'b1, rnd(), rnd(), rnd());
      checkOutput("midrst_valid", int'(evt_valid), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_round_done", int'(round_done), 0);
      checkOutput("midrst_id", int'(evt_id), 0);
      checkOutput("midrst_value", int'(evt_value), 0);
      for (int i = 0; i < 3; i++) checkOutput("midrst_avg", getAvg(i), 0);
      exp_avg = '{0, 0, 0};
      last_acc = 0;
      clearHoldoff();
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, rnd(), rnd(), rnd());
      runRound(0, 0, 0, 0, 0, 1'b0);

      $display("[TB] repeated single-sensor motion, sensor 1 at 90");
      for (int r = 0; r < 8; r++) runRound(1, 90, 0, 0, 1, 1'b0);

      $display("[TB] random rounds");
      for (int r = 0; r < 12; r++) runRound(0, 0, 0, 0, (r % 3 == 0) ? 1 : 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
